// File: rtl/job_sched_pkg.sv
// Shared types and constants for the job scheduler: FSM state encoding and
// the watchdog limit used when JOB_SCHED_WDOG_EN is defined.
package job_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    RUN,
    GAP,
    DONE
  } state_e;

  localparam int          WDOG_W     = 16;
  localparam logic [15:0] WDOG_LIMIT = 16'hFFFF;

endpackage

// File: rtl/job_sched_if.sv
// Control/observation bundle between a host (master) and job_sched (slave):
// job parameters, observed stream handshakes and accelerator mode outputs.
interface job_sched_if #(
  parameter int BATCH_W = 8,
  parameter int CNT_W   = 10
) ();

  logic               start;
  logic               abort;
  logic [BATCH_W-1:0] batch_num;
  logic [CNT_W-1:0]   wbeat_num;
  logic               src_valid;
  logic               src_ready;
  logic               dst_valid;
  logic               dst_ready;
  logic               dst_last;
  logic               matw;
  logic               run;
  logic               last;
  logic               busy;
  logic               done;
  logic [BATCH_W-1:0] batch_idx;
  logic               err;

  modport master (
    output start, abort, batch_num, wbeat_num,
    output src_valid, src_ready, dst_valid, dst_ready, dst_last,
    input  matw, run, last, busy, done, batch_idx, err
  );

  modport slave (
    input  start, abort, batch_num, wbeat_num,
    input  src_valid, src_ready, dst_valid, dst_ready, dst_last,
    output matw, run, last, busy, done, batch_idx, err
  );

endinterface

// File: rtl/job_sched_wdog.sv
// Inactivity counter: cleared by clr, advanced by inc, saturates at WDOG_LIMIT
// and flags expiry while sitting there.
module job_sched_wdog
  import job_sched_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [WDOG_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != WDOG_LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == WDOG_LIMIT);

endmodule

// File: rtl/job_sched.sv
// Job sequencer for a weight-load / multi-batch accelerator run.
// Optional watchdog (err output) is built only when JOB_SCHED_WDOG_EN is defined.
module job_sched
  import job_sched_pkg::*;
#(
  parameter int BATCH_W = 8,
  parameter int CNT_W   = 10
) (
  input  logic        clk,
  input  logic        reset,
  job_sched_if.slave  bus
);

  state_e             state_q, state_d;
  logic [BATCH_W-1:0] bnum_q, bnum_d;
  logic [BATCH_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]   wnum_q, wnum_d;
  logic [CNT_W-1:0]   beat_q, beat_d;
  logic               matw_q, matw_d;
  logic               run_q, run_d;
  logic               last_q, last_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               src_hs;
  logic               dst_end;
  logic               wdog_exp;

  assign src_hs  = bus.src_valid & bus.src_ready;
  assign dst_end = bus.dst_valid & bus.dst_ready & bus.dst_last;

  always_comb begin
    state_d = state_q;
    bnum_d  = bnum_q;
    idx_d   = idx_q;
    wnum_d  = wnum_q;
    beat_d  = beat_q;

    if (bus.abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_d = WLOAD;
            bnum_d  = bus.batch_num;
            wnum_d  = bus.wbeat_num;
            idx_d   = '0;
            beat_d  = '0;
          end
        end
        WLOAD: begin
          if (src_hs) begin
            beat_d = beat_q + 1'b1;
            if (beat_q == wnum_q) state_d = RUN;
          end
        end
        RUN: begin
          if (dst_end) state_d = (idx_q == bnum_q) ? DONE : GAP;
        end
        GAP: begin
          idx_d   = idx_q + 1'b1;
          state_d = RUN;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
      if (wdog_exp) state_d = IDLE;
    end

    // Outputs are decoded from the next state so they line up with state_q.
    matw_d = (state_d == WLOAD);
    run_d  = (state_d == RUN);
    last_d = (state_d == RUN) && (idx_d == bnum_d);
    busy_d = (state_d == WLOAD) || (state_d == RUN) || (state_d == GAP);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bnum_q  <= '0;
      idx_q   <= '0;
      wnum_q  <= '0;
      beat_q  <= '0;
      matw_q  <= 1'b0;
      run_q   <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bnum_q  <= bnum_d;
      idx_q   <= idx_d;
      wnum_q  <= wnum_d;
      beat_q  <= beat_d;
      matw_q  <= matw_d;
      run_q   <= run_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef JOB_SCHED_WDOG_EN
  logic err_q, err_d;
  logic wdog_clr, wdog_inc;

  // Any observed handshake or state transition counts as forward progress.
  assign wdog_clr = src_hs | (bus.dst_valid & bus.dst_ready) | (state_d != state_q);
  assign wdog_inc = (state_q == WLOAD) || (state_q == RUN);

  job_sched_wdog u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wdog_clr),
    .inc     (wdog_inc),
    .expired (wdog_exp)
  );

  always_comb begin
    err_d = err_q;
    if (!bus.abort && (state_q == IDLE) && bus.start) err_d = 1'b0;
    if (!bus.abort && wdog_exp) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign wdog_exp = 1'b0;
  assign bus.err  = 1'b0;
`endif

  assign bus.matw      = matw_q;
  assign bus.run       = run_q;
  assign bus.last      = last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.batch_idx = idx_q;

endmodule
